// File: rtl/keypad_pkg.sv
// Shared definitions for the keypad scan controller and the press FSM it serves.
// The press-state encodings let benches decode the press FSM state bus.
package keypad_pkg;

  localparam int NUM_COLS = 4;
  localparam int NUM_ROWS = 4;

  typedef enum logic [1:0] {
    DRIVE  = 2'd0,
    SAMPLE = 2'd1,
    LOCK   = 2'd2
  } scan_state_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DEBOUNCE = 2'd1,
    HOLD     = 2'd2,
    RELEASE  = 2'd3
  } press_state_t;

endpackage

// File: rtl/keypad_scan_ctrl_debounce.sv
// Debounce timer shared with the press FSM: counts while enabled and emits a
// one-cycle done pulse every DEBOUNCE_CYC cycles. Dropping en clears it at once.
module debounce_counter #(
  parameter int DEBOUNCE_CYC = 50000
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic done
);

  localparam int CW = $clog2(DEBOUNCE_CYC);
  localparam logic [CW-1:0] TERM = CW'(DEBOUNCE_CYC - 1);

  logic [CW-1:0] count;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the values from before the edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (!reset) begin
      count <= '0;
      done  <= 1'b0;
    end else if (!en) begin
      count <= '0;
      done  <= 1'b0;
    end else if (count == TERM) begin
      count <= '0;
      done  <= 1'b1;
    end else begin
      count <= count + 1'b1;
      done  <= 1'b0;
    end
  end

endmodule

// File: rtl/keypad_scan_ctrl.sv
// Column scanner for a 4x4 keypad: rotates a one-hot column drive, synchronizes
// the rows, freezes on a pressed column until the press FSM goes idle.
module keypad_scan_ctrl
  import keypad_pkg::*;
#(
  parameter int SETTLE_CYC   = 4,
  parameter int DEBOUNCE_CYC = 50000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_ROWS-1:0] rows_raw,
  input  logic                fsm_busy,
  input  logic                debounce_en,
  output logic [NUM_COLS-1:0] cols,
  output logic [NUM_ROWS-1:0] rows,
  output logic                countDone,
  output logic [1:0]          col_idx,
  output logic                scan_locked
);

  localparam int SW = $clog2(SETTLE_CYC + 1);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYC - 1);

  logic [NUM_ROWS-1:0] sync_q1, rows_sync;
  scan_state_t         state, state_nxt;
  logic [SW-1:0]       settle_cnt, settle_nxt;
  logic [1:0]          col_idx_nxt;
  logic                guard, guard_nxt;

  always_ff @(posedge clk) begin
    if (!reset) begin
      sync_q1    <= '0;
      rows_sync  <= '0;
      state      <= DRIVE;
      settle_cnt <= '0;
      col_idx    <= '0;
      guard      <= 1'b0;
    end else begin
      sync_q1    <= rows_raw;
      rows_sync  <= sync_q1;
      state      <= state_nxt;
      settle_cnt <= settle_nxt;
      col_idx    <= col_idx_nxt;
      guard      <= guard_nxt;
    end
  end

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_nxt   = state;
    settle_nxt  = settle_cnt;
    col_idx_nxt = col_idx;
    guard_nxt   = guard;
    unique case (state)
      DRIVE: begin
        if (settle_cnt == SETTLE_LAST) begin
          settle_nxt = '0;
          state_nxt  = SAMPLE;
        end else begin
          settle_nxt = settle_cnt + 1'b1;
        end
      end
      SAMPLE: begin
        if (rows_sync != '0) begin
          guard_nxt = 1'b0;
          state_nxt = LOCK;
        end else begin
          col_idx_nxt = col_idx + 2'd1;
          state_nxt   = DRIVE;
        end
      end
      LOCK: begin
        // Guard holds LOCK through its entry cycle, before the press FSM has
        // had a chance to raise busy for this key.
        guard_nxt = 1'b1;
        if (guard && !fsm_busy) begin
          col_idx_nxt = col_idx + 2'd1;
          state_nxt   = DRIVE;
        end
      end
      default: state_nxt = DRIVE;
    endcase
  end

  assign cols        = NUM_COLS'(1) << col_idx;
  assign rows        = (state == DRIVE) ? '0 : rows_sync;
  assign scan_locked = (state == LOCK);

  debounce_counter #(
    .DEBOUNCE_CYC(DEBOUNCE_CYC)
  ) u_debounce (
    .clk  (clk),
    .reset(reset),
    .en   (debounce_en),
    .done (countDone)
  );

endmodule
